sys_bridge: RTL and testbench
=============================

# sys_bridge

CPU-side initiator for the memory-mapped peripheral bus: accepts one load/store request at a time from the CPU data-memory stage, decodes it to one of up to six peripheral slots (timers first), and drives the device-side address, data and write-enable signals. Returns registered read data with an ack/err handshake. Collects device interrupt lines into the registered `hwint` vector consumed by CP0.

## Interface
Parameters:
- `DEV_NUM`, 2: number of populated device slots, 1..6.
- `BASE`, 32'h0000_7F00: bus window base. Slot i occupies `BASE + 16*i` .. `BASE + 16*i + 15`.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `clr`  in  1: reset, asynchronous, active-high.
- `cpu_req`  in  1: request valid; sampled only in IDLE.
- `cpu_we`  in  1: 1 = store, 0 = load.
- `cpu_addr`  in  32: byte address.
- `cpu_wdata`  in  32: store data.
- `cpu_busy`  out  1: request in flight; CPU stalls.
- `cpu_ack`  out  1: one-cycle completion pulse.
- `cpu_err`  out  1: qualifies `cpu_ack`; access rejected.
- `cpu_rdata`  out  32: load data, valid while `cpu_ack`.
- `ADD_O`  out  2: device register index, bits [3:2] of the latched address.
- `DAT_O`  out  32: device write data.
- `WE_O`  out  DEV_NUM: one-hot per-slot write strobe.
- `DAT_I`  in  32*DEV_NUM: flattened device read data, slot i at [32i+31:32i].
- `dev_irq`  in  DEV_NUM: device interrupt requests, level.
- `hwint`  out  6: registered interrupt vector; bit i = slot i; bits >= DEV_NUM tie 0.

## Operation
- FSM states IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if `cpu_req`, latch addr/we/wdata into request registers, compute decode, go ACCESS. Otherwise stay.
- ACCESS: drive `ADD_O`, `DAT_O` from the latched request. If the request is a legal store, assert `WE_O[slot]`. If it is a load, capture the selected `DAT_I` slice into `cpu_rdata`. Go RESP.
- RESP: `cpu_ack`=1. `cpu_err` holds the decode error. Go IDLE.
- Decode is legal iff all of the following hold:
  - `addr[31:8] == BASE[31:8]`
  - `addr[7:4] < DEV_NUM`
  - `addr[1:0] == 0`
- Store-only error: a store to register index 2 (COUNT) or 3 is illegal.
- Error access: no `WE_O` pulse, `cpu_rdata` = 0, `cpu_err`=1 with ack.
- Load from register index 3 is legal and returns the device value.
- `cpu_busy` = 1 in ACCESS and RESP. It is also 1 combinationally in IDLE when `cpu_req` is high.
- `hwint` register is updated every cycle from `dev_irq`. It is independent of the FSM.

## Timing
- Reset values:
  - `cpu_ack`, `cpu_err`, `WE_O`, `hwint` = 0.
  - `cpu_rdata`, `DAT_O` = 0.
  - `ADD_O` = 0.
  - `cpu_busy` = 0 (with `cpu_req` low).
- Latency: `cpu_req` sampled at edge n; `WE_O` high for exactly the cycle between edges n and n+1. Device write occurs at edge n+1. `cpu_ack` is high in the cycle after edge n+1.
- Fixed 3-cycle occupancy per access. The earliest next request is sampled in the cycle after `cpu_ack`, back in IDLE.
- `cpu_req` asserted in ACCESS or RESP is ignored. The CPU holds it until ack.
- `WE_O` is never asserted outside ACCESS. It is never multi-hot.
- `hwint` lags `dev_irq` by 1 cycle, or by 2 cycles with the synchronizer.
- `clr` mid-access: immediate return to IDLE, all outputs cleared, no write strobe, no ack for the aborted request.
- An IRQ edge that coincides with `cpu_ack` is still captured. There is no interaction between the FSM and `hwint`.

## Configuration
- `SYS_BRIDGE_IRQ_SYNC_EN` defined: each `dev_irq` bit passes through a 2-flop synchronizer before `hwint`. Latency is 2 cycles; reset 0.
- Undefined: single register stage, latency 1 cycle.

## Structure
- Shared package `bus_pkg`:
  - FSM state encoding (IDLE/ACCESS/RESP).
  - Register index constants CTRL=0, PRESET=1, COUNT=2.
  - Default `BASE` and max slot count 6.
- One sub-module, `bus_decode`: combinational address → {slot index, legal, store-legal}. It is instantiated once on the latched address.

## Test plan
- Store 0x0000_0009 to 0x7F00 -> `WE_O`=2'b01 for one cycle, `ADD_O`=0, `DAT_O`=0x9; ack at cycle 3, err 0.
- Load 0x7F14 with slot 1 `DAT_I`=0x1234 -> `ADD_O`=1, `cpu_rdata`=0x1234 with ack, no `WE_O`.
- Store to 0x7F08 (COUNT) and store to 0x7F20 (slot 2 absent, DEV_NUM=2) -> no `WE_O`, ack with err=1, rdata 0.
- Load unaligned 0x7F05 -> err=1; then immediate legal load 0x7F04 -> err=0, correct data.
- `clr` pulsed during ACCESS of a store -> `WE_O` drops at once, no ack, FSM IDLE; next request completes normally.
- `dev_irq`=2'b10 raised for 1 cycle -> `hwint`=6'b000010 one cycle later (two with `SYS_BRIDGE_IRQ_SYNC_EN`), clears when `dev_irq` drops.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side peripheral bus: FSM encoding,
// device register indices and default window placement.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_t;

  localparam logic [1:0]  REG_CTRL   = 2'd0;
  localparam logic [1:0]  REG_PRESET = 2'd1;
  localparam logic [1:0]  REG_COUNT  = 2'd2;

  localparam logic [31:0] BUS_BASE_DEFAULT = 32'h0000_7F00;
  localparam int          BUS_MAX_SLOTS    = 6;

  // Only CTRL and PRESET are writable; COUNT and index 3 are read-only.
  function automatic logic store_reg_ok(input logic [1:0] idx);
    return (idx == REG_CTRL) || (idx == REG_PRESET);
  endfunction

endpackage

// File: rtl/bus_decode.sv
// Combinational address decode for the peripheral window:
// slot index, load legality and store legality.
module bus_decode
  import bus_pkg::*;
#(
  parameter int          DEV_NUM = 2,
  parameter logic [31:0] BASE    = BUS_BASE_DEFAULT
) (
  input  logic [31:0] addr,
  output logic [2:0]  slot,
  output logic        legal,
  output logic        store_legal
);

  localparam logic [3:0] DEV_LIMIT = 4'(DEV_NUM);

  always_comb begin
    slot        = addr[6:4];
    legal       = (addr[31:8] == BASE[31:8]) &&
                  (addr[7:4] < DEV_LIMIT) &&
                  (addr[1:0] == 2'b00);
    store_legal = legal && store_reg_ok(addr[3:2]);
  end

endmodule

// File: rtl/sys_bridge.sv
// CPU-to-peripheral bus initiator: one access at a time, 3-cycle occupancy,
// plus interrupt collection into hwint. Macro SYS_BRIDGE_IRQ_SYNC_EN adds a 2-flop IRQ synchronizer.
module sys_bridge
  import bus_pkg::*;
#(
  parameter int          DEV_NUM = 2,
  parameter logic [31:0] BASE    = BUS_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_busy,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  output logic [31:0]              cpu_rdata,
  output logic [1:0]               ADD_O,
  output logic [31:0]              DAT_O,
  output logic [DEV_NUM-1:0]       WE_O,
  input  logic [32*DEV_NUM-1:0]    DAT_I,
  input  logic [DEV_NUM-1:0]       dev_irq,
  output logic [BUS_MAX_SLOTS-1:0] hwint
);

  bus_state_t state, state_nxt;

  logic                     req_we;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic                     err_q;
  logic [2:0]               slot;
  logic                     legal;
  logic                     store_legal;
  logic [31:0]              sel_data;
  logic [BUS_MAX_SLOTS-1:0] irq_ext;

  bus_decode #(
    .DEV_NUM (DEV_NUM),
    .BASE    (BASE)
  ) u_decode (
    .addr        (req_addr),
    .slot        (slot),
    .legal       (legal),
    .store_legal (store_legal)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    WE_O      = '0;
    unique case (state)
      ST_IDLE:   if (cpu_req) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        state_nxt = ST_RESP;
        if (req_we && store_legal) begin
          for (int i = 0; i < DEV_NUM; i++) WE_O[i] = (slot == 3'(i));
        end
      end
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_busy = (state != ST_IDLE) || cpu_req;
  assign cpu_ack  = (state == ST_RESP);
  assign cpu_err  = cpu_ack && err_q;
  assign ADD_O    = req_addr[3:2];
  assign DAT_O    = req_wdata;

  // Mux by loop so an out-of-range slot can never index past DAT_I.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      if (slot == 3'(i)) sel_data = DAT_I[32*i +: 32];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (state == ST_IDLE && cpu_req) begin
      req_we    <= cpu_we;
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q     <= 1'b0;
      cpu_rdata <= '0;
    end else if (state == ST_ACCESS) begin
      err_q     <= req_we ? !store_legal : !legal;
      cpu_rdata <= (!req_we && legal) ? sel_data : '0;
    end
  end

  always_comb begin
    irq_ext                = '0;
    irq_ext[DEV_NUM-1:0]   = dev_irq;
  end

`ifdef SYS_BRIDGE_IRQ_SYNC_EN
  logic [BUS_MAX_SLOTS-1:0] irq_meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      irq_meta <= '0;
      hwint    <= '0;
    end else begin
      irq_meta <= irq_ext;
      hwint    <= irq_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge clr) begin
    if (clr) hwint <= '0;
    else     hwint <= irq_ext;
  end
`endif

endmodule

// File: tb/tb_sys_bridge.sv
// Scoreboard bench for sys_bridge: stimulus pushes expected responses, a monitor
// pops them on each ack; hwint is checked every cycle against a delay-line model.
module tb_sys_bridge;

  localparam int          DEV_NUM = 2;
  localparam logic [31:0] BASE    = 32'h0000_7F00;
`ifdef SYS_BRIDGE_IRQ_SYNC_EN
  localparam int          IRQ_LAT = 2;
`else
  localparam int          IRQ_LAT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  clr;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_busy;
  logic                  cpu_ack;
  logic                  cpu_err;
  logic [31:0]           cpu_rdata;
  logic [1:0]            ADD_O;
  logic [31:0]           DAT_O;
  logic [DEV_NUM-1:0]    WE_O;
  logic [32*DEV_NUM-1:0] DAT_I;
  logic [DEV_NUM-1:0]    dev_irq;
  logic [5:0]            hwint;

  sys_bridge #(
    .DEV_NUM (DEV_NUM),
    .BASE    (BASE)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .ADD_O     (ADD_O),
    .DAT_O     (DAT_O),
    .WE_O      (WE_O),
    .DAT_I     (DAT_I),
    .dev_irq   (dev_irq),
    .hwint     (hwint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  we;
    logic [1:0]  add;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected response computed straight from the address-map rules.
  function automatic exp_t model(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [63:0] dat);
    exp_t e;
    int   slot;
    int   idx;
    bit   legal;
    bit   ok;
    slot  = int'(addr[7:4]);
    idx   = int'(addr[3:2]);
    legal = ((addr >> 8) == (BASE >> 8)) && (slot < DEV_NUM) && ((addr % 4) == 0);
    ok    = we ? (legal && (idx == 0 || idx == 1)) : legal;
    e.err   = !ok;
    e.we    = (we && ok) ? 2'(1 << slot) : 2'b00;
    e.rdata = (!we && ok) ? dat[32*slot +: 32] : 32'h0;
    e.add   = 2'(idx);
    e.dat   = wdata;
    return e;
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [63:0] dat, input int gap);
    bit got;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    DAT_I     = dat;
    cpu_req   = 1'b1;
    sb.push_back(model(we, addr, wdata, dat));
    #1 checkOutput("busy_on_req", 32'(cpu_busy), 32'h1);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL ack_timeout: got no ack expected ack within 8 cycles (addr %h)", addr);
    end
    for (int g = 0; g < gap; g++) @(negedge clk);
  endtask

  // Monitor: tracks the bus protocol abstractly and scores each ack.
  bit          access_next = 0;
  bit          in_flight   = 0;
  bit          skip_edge   = 0;
  int          cycles;
  int          we_cnt;
  logic [1:0]  we_acc;
  logic [1:0]  cap_add;
  logic [31:0] cap_dat;

  always @(posedge clr) begin
    access_next = 0;
    in_flight   = 0;
    skip_edge   = 0;
    sb.delete();
  end

  always @(posedge clk) begin
    if (!clr) begin
      if (skip_edge) skip_edge = 0;
      else if (!in_flight && !access_next && cpu_req) access_next = 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      if (access_next) begin
        access_next = 0;
        in_flight   = 1;
        cycles      = 1;
        we_acc      = WE_O;
        we_cnt      = (WE_O != 0) ? 1 : 0;
        cap_add     = ADD_O;
        cap_dat     = DAT_O;
      end else if (in_flight) begin
        cycles++;
        we_acc |= WE_O;
        if (WE_O != 0) we_cnt++;
      end else if (WE_O != 0) begin
        checkOutput("we_idle", 32'(WE_O), 32'h0);
      end
      if (cpu_ack) begin
        if (!in_flight || sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_ack: got ack expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput("ack_latency", 32'(cycles), 32'd2);
          checkOutput("err",         32'(cpu_err), 32'(e.err));
          checkOutput("rdata",       cpu_rdata, e.rdata);
          checkOutput("we_strobe",   32'(we_acc), 32'(e.we));
          checkOutput("we_cycles",   32'(we_cnt), (e.we != 0) ? 32'd1 : 32'd0);
          checkOutput("add_o",       32'(cap_add), 32'(e.add));
          checkOutput("dat_o",       cap_dat, e.dat);
          in_flight = 0;
          skip_edge = 1;
        end
      end
    end
  end

  // Interrupt path: hwint is dev_irq delayed by IRQ_LAT cycles.
  logic [1:0] irq_hist [2];

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      irq_hist[0] = '0;
      irq_hist[1] = '0;
    end else begin
      irq_hist[1] = irq_hist[0];
      irq_hist[0] = dev_irq;
    end
  end

  always @(negedge clk) begin
    if (!clr) checkOutput("hwint", 32'(hwint), 32'({4'b0, irq_hist[IRQ_LAT-1]}));
  end

  always @(negedge clk) begin
    if ($urandom_range(0, 2) == 0) dev_irq = 2'($urandom);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        we;
    logic [31:0] addr;
    clr       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    DAT_I     = '0;
    dev_irq   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack",   32'(cpu_ack),  32'h0);
    checkOutput("rst_err",   32'(cpu_err),  32'h0);
    checkOutput("rst_we",    32'(WE_O),     32'h0);
    checkOutput("rst_hwint", 32'(hwint),    32'h0);
    checkOutput("rst_rdata", cpu_rdata,     32'h0);
    checkOutput("rst_dat",   DAT_O,         32'h0);
    checkOutput("rst_add",   32'(ADD_O),    32'h0);
    checkOutput("rst_busy",  32'(cpu_busy), 32'h0);
    clr = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 32'h0000_7F00, 32'h0000_0009, 64'h0, 1);
    applyStimulus(1'b0, 32'h0000_7F14, 32'hAAAA_0000, {32'h0000_1234, 32'hDEAD_BEEF}, 1);
    applyStimulus(1'b1, 32'h0000_7F08, 32'h1111_2222, 64'h0, 1);
    applyStimulus(1'b1, 32'h0000_7F20, 32'h3333_4444, 64'h0, 1);
    applyStimulus(1'b0, 32'h0000_7F05, 32'h0, {32'h5555_6666, 32'h7777_8888}, 0);
    applyStimulus(1'b0, 32'h0000_7F04, 32'h0, {32'h5555_6666, 32'h7777_8888}, 1);
    applyStimulus(1'b0, 32'h0000_7F1C, 32'h0, {32'hCAFE_F00D, 32'h0}, 1);

    // Abort a legal store while its strobe is up.
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_7F10;
    cpu_wdata = 32'h0000_0055;
    cpu_req   = 1'b1;
    @(negedge clk);
    #1 checkOutput("we_before_clr", 32'(WE_O), 32'h2);
    clr     = 1'b1;
    cpu_req = 1'b0;
    #1;
    checkOutput("we_after_clr",   32'(WE_O),     32'h0);
    checkOutput("busy_after_clr", 32'(cpu_busy), 32'h0);
    checkOutput("ack_after_clr",  32'(cpu_ack),  32'h0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_ack_after_abort", 32'(cpu_ack), 32'h0);
    end
    applyStimulus(1'b1, 32'h0000_7F14, 32'h0000_00AA, 64'h0, 1);

    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       addr = BASE + 32'($urandom_range(0, 63));
        1:       addr = BASE + 32'(16 * $urandom_range(0, DEV_NUM - 1) + 4 * $urandom_range(0, 3));
        2:       addr = $urandom;
        default: addr = BASE + 32'(256 * $urandom_range(1, 3));
      endcase
      applyStimulus(we, addr, $urandom, {$urandom, $urandom}, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
